// File: rtl/mod3_pkg.sv
// mod3_pkg: residue and FSM encodings shared by the mod-3 transmitter and detector
package mod3_pkg;
  typedef enum logic [1:0] {ZERO = 2'd0, ONE = 2'd1, TWO = 2'd2} res_t;
  typedef enum logic [1:0] {IDLE, DATA, CHECK0, CHECK1} state_t;
  function automatic res_t mod3_step(input res_t r, input logic b);
    return r == ZERO ? (b ? ONE : ZERO) :
           r == ONE  ? (b ? ZERO : TWO) :
                       (b ? TWO : ONE);
  endfunction
  function automatic logic [1:0] mod3_check(input res_t r);
    return r == ONE ? 2'b10 : r == TWO ? 2'b01 : 2'b00;
  endfunction
endpackage

// File: rtl/mod3_residue.sv
// mod3_residue: running mod-3 residue of an MSB-first bit stream
module mod3_residue
  import mod3_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic b,
  output res_t r
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= ZERO;
    else r <= clr ? ZERO : en ? mod3_step(r, b) : r;
endmodule

// File: rtl/mod3_frame_tx.sv
// mod3_frame_tx: serialises a word MSB-first and appends 2 check bits
// so that each (WIDTH+2)-bit frame is a multiple of 3.
module mod3_frame_tx
  import mod3_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_last
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic [1:0]       c;
  res_t             res;
  logic             accept;
  logic [1:0]       c_nxt;
  assign in_ready = state == IDLE || state == CHECK1;
  assign accept   = in_valid && in_ready;
  // the bit on the line this cycle is sh MSB; fold it in before deriving c
  assign c_nxt    = mod3_check(mod3_step(res, sh[WIDTH-1]));
  mod3_residue u_res (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state == DATA),
    .b    (sh[WIDTH-1]),
    .r    (res)
  );
  // outputs are loaded with the value for the state being entered, so the
  // first data bit is on the line the cycle after the accept edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      c        <= '0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else
      case (state)
        DATA: begin
          sh     <= {sh[WIDTH-2:0], 1'b0};
          tx_bit <= cnt == '0 ? c_nxt[1] : sh[WIDTH-2];
          if (cnt == '0) begin
            state <= CHECK0;
            c     <= c_nxt;
          end else cnt <= cnt - CNT_W'(1);
        end
        CHECK0: begin
          state   <= CHECK1;
          tx_bit  <= c[0];
          tx_last <= 1'b1;
        end
        default: begin
          state    <= accept ? DATA : IDLE;
          tx_valid <= accept;
          tx_last  <= 1'b0;
          tx_bit   <= accept && in_data[WIDTH-1];
          if (accept) begin
            sh  <= in_data;
            cnt <= CNT_W'(WIDTH - 1);
          end
        end
      endcase
endmodule

// File: tb/tb_mod3_frame_tx.sv
// tb_mod3_frame_tx: directed and random frame checks for mod3_frame_tx
module tb_mod3_frame_tx;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       tx_bit, tx_valid, tx_last;
  int         total = 0;
  int         bad = 0;

  mod3_frame_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int det(input logic [9:0] f);
    int r = 0;
    for (int i = 9; i >= 0; i--) r = (2 * r + int'(f[i])) % 3;
    return r;
  endfunction

  function automatic logic [9:0] model(input logic [7:0] w);
    int c = (3 - int'(w) % 3) % 3;
    return {w, c[1:0]};
  endfunction

  // call from posedge+#1 with the DUT idle
  task automatic run_frame(input logic [7:0] w, output logic [9:0] f);
    int nv = 0;
    int lpos = -1;
    f = '0;
    in_valid = 1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 0;
    in_data  = 8'h3C;
    chk("busy", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) nv++;
      if (tx_last) lpos = lpos < 0 ? i : 99;
      f = {f[8:0], tx_bit};
      @(posedge clk); #1;
    end
    chk("valid_cnt", nv, 10);
    chk("last_pos", lpos, 9);
    chk("idle_after", tx_valid, 0);
  endtask

  initial begin
    logic [9:0]  f;
    logic [29:0] s;
    logic [7:0]  w;
    logic [7:0]  words [3] = '{8'h01, 8'h02, 8'h03};
    int          k, lastn, rdy_bad;
    int          flip_ok;
    #2;
    chk("rst_bit", tx_bit, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    run_frame(8'h05, f); chk("f05", f, 10'h015); chk("f05_det", det(f), 0);
    run_frame(8'h07, f); chk("f07", f, 10'h01E);
    run_frame(8'hFF, f); chk("fFF", f, 10'h3FC);
    run_frame(8'h00, f); chk("f00", f, 10'h000);

    // back-to-back frames; in_data scrambled outside CHECK1 must be ignored
    in_valid = 1;
    in_data  = words[0];
    k = 1; lastn = 0; rdy_bad = 0; s = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      chk("b2b_valid", tx_valid, 1);
      if (tx_last) lastn++;
      if (tx_last !== (i % 10 == 9)) rdy_bad++;
      if (in_ready !== (i % 10 == 9)) rdy_bad++;
      s = {s[28:0], tx_bit};
      if (tx_last && k < 3) in_data = words[k++];
      else if (tx_last) in_valid = 0;
      else in_data = 8'hA5 ^ 8'(i);
      @(posedge clk); #1;
    end
    chk("b2b_frames", s, {10'h006, 10'h009, 10'h00C});
    chk("b2b_lastn", lastn, 3);
    chk("b2b_ready", rdy_bad, 0);
    chk("b2b_idle", tx_valid, 0);

    // asynchronous reset in the middle of DATA
    in_valid = 1;
    in_data  = 8'h05;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_bit", tx_bit, 0);
    chk("arst_last", tx_last, 0);
    chk("arst_ready", in_ready, 1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("arst_hold_last", tx_last, 0);
    end
    @(negedge clk);
    rst_n = 1;
    #1 chk("arst_rel_ready", in_ready, 1);
    @(posedge clk); #1;
    run_frame(8'h05, f); chk("arst_f05", f, 10'h015);

    // random words through the detector model
    flip_ok = 1;
    for (int n = 0; n < 1000; n++) begin
      w = 8'($urandom);
      run_frame(w, f);
      chk("rnd_frame", f, model(w));
      chk("rnd_det", det(f), 0);
      for (int j = 0; j < 10; j++) begin
        logic [9:0] g = f ^ (10'd1 << j);
        if (det(g) == 0) flip_ok = 0;
      end
    end
    chk("rnd_flip", flip_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
